// File: rtl/axi4_lite_wr_arbiter_pkg.sv
// Shared AXI4-Lite definitions: bus widths, arbiter FSM states and response codes.
// The write arbiter and the future read arbiter both import this package.
package axi4_lite_Defs;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // Grant index width, never narrower than one bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_wr_arbiter_rr_arb.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
// Shared between the write arbiter and the future read arbiter.
module axi4_lite_rr_arb #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] grant,
  output logic          any_req
);

  localparam int unsigned NU = N;

  int unsigned idx;
  logic        found;

  // Offsets run 1..N so that 'last' itself is considered only after everyone else.
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= NU; off++) begin
      idx = (32'(last) + off) % NU;
      if (!found && req[idx]) begin
        grant = GW'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi4_lite_wr_arbiter.sv
// Shares one AXI4-Lite slave write port between N_MASTERS masters, serialising whole
// AW/W/B transactions with round-robin priority and one transaction in flight.
module axi4_lite_wr_arbiter
  import axi4_lite_Defs::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int Addr_Width = ADDR_WIDTH,
  parameter int Data_Width = DATA_WIDTH,
  localparam int Strb_Width = Data_Width / 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [N_MASTERS*Addr_Width-1:0] m_awaddr,
  input  logic [N_MASTERS-1:0]            m_awvalid,
  output logic [N_MASTERS-1:0]            m_awready,
  input  logic [N_MASTERS*Data_Width-1:0] m_wdata,
  input  logic [N_MASTERS*Strb_Width-1:0] m_wstrb,
  input  logic [N_MASTERS-1:0]            m_wvalid,
  output logic [N_MASTERS-1:0]            m_wready,
  output logic [N_MASTERS*2-1:0]          m_bresp,
  output logic [N_MASTERS-1:0]            m_bvalid,
  input  logic [N_MASTERS-1:0]            m_bready,
  output logic [Addr_Width-1:0]           s_awaddr,
  output logic                            s_awvalid,
  input  logic                            s_awready,
  output logic [Data_Width-1:0]           s_wdata,
  output logic [Strb_Width-1:0]           s_wstrb,
  output logic                            s_wvalid,
  input  logic                            s_wready,
  input  logic [1:0]                      s_bresp,
  input  logic                            s_bvalid,
  output logic                            s_bready
);

  localparam int GW = grant_width(N_MASTERS);

  state          cur_state;
  logic [GW-1:0] grant;
  logic [GW-1:0] last;
  logic [GW-1:0] pick;
  logic          any_req;
  int unsigned   gsel;

  axi4_lite_rr_arb #(
    .N  (N_MASTERS),
    .GW (GW)
  ) u_rr_arb (
    .req     (m_awvalid),
    .last    (last),
    .grant   (pick),
    .any_req (any_req)
  );

  assign gsel = 32'(grant);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cur_state <= IDLE;
      grant     <= '0;
      last      <= GW'(N_MASTERS - 1);
    end else begin
      case (cur_state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            cur_state <= ADDR;
          end
        end
        ADDR: begin
          if (s_awvalid && s_awready) cur_state <= DATA;
        end
        DATA: begin
          if (s_wvalid && s_wready) cur_state <= RESP;
        end
        RESP: begin
          if (s_bvalid && s_bready) begin
            last      <= grant;
            cur_state <= IDLE;
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

  // Pure combinational steering: only the active channel of the granted master is wired.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    case (cur_state)
      ADDR: begin
        s_awaddr        = m_awaddr[gsel*Addr_Width +: Addr_Width];
        s_awvalid       = m_awvalid[gsel];
        m_awready[gsel] = s_awready;
      end
      DATA: begin
        s_wdata        = m_wdata[gsel*Data_Width +: Data_Width];
        s_wstrb        = m_wstrb[gsel*Strb_Width +: Strb_Width];
        s_wvalid       = m_wvalid[gsel];
        m_wready[gsel] = s_wready;
      end
      RESP: begin
        m_bvalid[gsel]        = s_bvalid;
        m_bresp[gsel*2 +: 2]  = s_bresp;
        s_bready              = m_bready[gsel];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_wr_arbiter.sv
// Self-checking bench for axi4_lite_wr_arbiter: randomized masters and slave, with a
// transaction-level round-robin model predicting the winner and each channel's routing.
module tb_axi4_lite_wr_arbiter;
  import axi4_lite_Defs::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [N*AW-1:0] m_awaddr;
  logic [N-1:0]    m_awvalid;
  logic [N-1:0]    m_awready;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N-1:0]    m_wvalid;
  logic [N-1:0]    m_wready;
  logic [N*2-1:0]  m_bresp;
  logic [N-1:0]    m_bvalid;
  logic [N-1:0]    m_bready;
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;

  always #5 ACLK = ~ACLK;

  axi4_lite_wr_arbiter #(
    .N_MASTERS  (N),
    .Addr_Width (AW),
    .Data_Width (DW)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending requests with payloads, plus the last master served.
  bit            pend   [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  logic [SW-1:0] p_strb [N];
  int            model_last = N - 1;

  function automatic int expected_winner();
    for (int off = 1; off <= N; off++) begin
      if (pend[(model_last + off) % N]) return (model_last + off) % N;
    end
    return -1;
  endfunction

  function automatic bit all_zero();
    return (m_awready == '0) && (m_wready == '0) && (m_bvalid == '0) && (m_bresp == '0) &&
           (s_awaddr == '0) && (s_awvalid == 1'b0) && (s_wdata == '0) && (s_wstrb == '0) &&
           (s_wvalid == 1'b0) && (s_bready == 1'b0);
  endfunction

  task automatic load(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    pend[i]   = 1'b1;
    p_addr[i] = a;
    p_data[i] = d;
    p_strb[i] = s;
  endtask

  task automatic load_rand(input int i);
    logic [31:0] r;
    r = $urandom;
    load(i, {r[AW-1:4], 4'(i)}, $urandom, SW'($urandom));
  endtask

  task automatic drive_quiet();
    m_awaddr  = '0;
    m_awvalid = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bresp   = 2'b00;
    s_bvalid  = 1'b0;
  endtask

  // One transaction as seen by the model: idle cycles, then AW, W, B phases.
  // If abort is set, ARESETN is dropped asynchronously in the middle of the W phase.
  task automatic run_txn(input int aw_delay, input int aw_stall, input int w_stall,
                         input int b_stall, input logic [1:0] resp, input bit abort);
    int         exp;
    int         cyc;
    int         phase;
    int         cnt;
    bit         done;
    bit         ok_idle, ok_addr, ok_data, ok_resp, ok_other;
    logic [1:0] resp_seen;
    exp = expected_winner();
    if (exp < 0) return;
    phase = 0; cnt = 0; cyc = 0; done = 1'b0; resp_seen = 2'bxx;
    ok_idle = 1'b1; ok_addr = 1'b1; ok_data = 1'b1; ok_resp = 1'b1; ok_other = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge ACLK);
      if (phase == 0 && cyc >= aw_delay + 1) begin
        phase = 1;
        cnt   = 0;
      end
      for (int i = 0; i < N; i++) begin
        m_awaddr[i*AW +: AW] = p_addr[i];
        m_wdata[i*DW +: DW]  = p_data[i];
        m_wstrb[i*SW +: SW]  = p_strb[i];
        m_awvalid[i] = pend[i] && (cyc >= aw_delay) && !(i == exp && phase >= 2);
        m_wvalid[i]  = pend[i] && !(i == exp && phase >= 3);
      end
      m_bready  = N'($urandom);
      s_awready = (phase == 1) ? (cnt >= aw_stall) : 1'($urandom);
      s_wready  = (phase == 2) ? (cnt >= w_stall)  : 1'($urandom);
      if (phase == 3 && cnt >= b_stall) begin
        s_bvalid = 1'b1;
        s_bresp  = resp;
      end else begin
        s_bvalid = (phase == 3) ? 1'b0 : 1'($urandom);
        s_bresp  = 2'($urandom);
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (i != exp && (m_awready[i] || m_wready[i] || m_bvalid[i] || m_bresp[i*2 +: 2] != 2'b00))
          ok_other = 1'b0;
      end
      case (phase)
        0: if (!all_zero()) ok_idle = 1'b0;
        1: begin
          if (s_awvalid !== 1'b1 || s_awaddr !== p_addr[exp] || m_awready[exp] !== s_awready ||
              s_wvalid !== 1'b0 || m_wready[exp] !== 1'b0 || m_bvalid[exp] !== 1'b0 ||
              s_bready !== 1'b0)
            ok_addr = 1'b0;
          if (s_awready) begin phase = 2; cnt = 0; end else cnt++;
        end
        2: begin
          if (s_awvalid !== 1'b0 || m_awready[exp] !== 1'b0 || s_wvalid !== 1'b1 ||
              s_wdata !== p_data[exp] || s_wstrb !== p_strb[exp] || m_wready[exp] !== s_wready ||
              m_bvalid[exp] !== 1'b0 || s_bready !== 1'b0)
            ok_data = 1'b0;
          if (abort && cnt == 1) begin
            #2 ARESETN = 1'b0;
            #1;
            n_checks++;
            if (!all_zero()) $display("FAIL reset_mid_data: outputs not all zero under reset");
            else n_pass++;
            return;
          end
          if (s_wready) begin phase = 3; cnt = 0; end else cnt++;
        end
        default: begin
          if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || m_bvalid[exp] !== s_bvalid ||
              s_bready !== m_bready[exp] || (s_bvalid && m_bresp[exp*2 +: 2] !== s_bresp))
            ok_resp = 1'b0;
          if (s_bvalid && m_bready[exp]) begin
            resp_seen = m_bresp[exp*2 +: 2];
            done = 1'b1;
          end else if (cnt < b_stall) cnt++;
        end
      endcase
      cyc++;
    end
    n_checks++;
    if (!done) $display("FAIL txn_timeout: master %0d reached phase %0d, required completion", exp, phase);
    else n_pass++;
    n_checks++;
    if (!ok_idle) $display("FAIL idle_outputs: master %0d, nonzero output in idle, required all 0", exp);
    else n_pass++;
    n_checks++;
    if (!ok_addr) $display("FAIL addr_phase: master %0d, addr routing wrong, required %h", exp, p_addr[exp]);
    else n_pass++;
    n_checks++;
    if (!ok_data) $display("FAIL data_phase: master %0d, data routing wrong, required %h/%h", exp, p_data[exp], p_strb[exp]);
    else n_pass++;
    n_checks++;
    if (!ok_resp) $display("FAIL resp_phase: master %0d, response routing wrong", exp);
    else n_pass++;
    n_checks++;
    if (!ok_other) $display("FAIL others_quiet: master %0d granted, another master saw ready/bvalid/bresp", exp);
    else n_pass++;
    n_checks++;
    if (resp_seen !== resp) $display("FAIL bresp_value: master %0d got %b, required %b", exp, resp_seen, resp);
    else n_pass++;
    pend[exp]  = 1'b0;
    model_last = exp;
  endtask

  task automatic idle_check(input string name);
    @(negedge ACLK);
    drive_quiet();
    #1;
    n_checks++;
    if (!all_zero()) $display("FAIL %s: outputs not all zero, s_awvalid=%b m_bvalid=%b", name, s_awvalid, m_bvalid);
    else n_pass++;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    drive_quiet();
    m_awvalid = '1;
    m_wvalid  = '1;
    s_bvalid  = 1'b1;
    s_bresp   = 2'b11;
    repeat (3) @(negedge ACLK);
    #1;
    n_checks++;
    if (!all_zero()) $display("FAIL reset_outputs: outputs nonzero during reset, required 0");
    else n_pass++;
    drive_quiet();
    @(negedge ACLK);
    ARESETN = 1'b1;
    idle_check("after_reset");
  endtask

  task automatic test_single();
    load(0, 32'h10, 32'hDEADBEEF, 4'hF);
    run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
    idle_check("single_back_to_idle");
  endtask

  task automatic test_simultaneous();
    load_rand(0);
    load_rand(1);
    run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
    run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
    // Both masters keep re-requesting: grants must alternate.
    for (int r = 0; r < 4; r++) begin
      load_rand(0);
      load_rand(1);
      run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      load_rand(model_last == 0 ? 1 : 0);
    end
    while (expected_winner() >= 0) run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
  endtask

  task automatic test_stalls();
    load_rand(0);
    load_rand(1);
    run_txn(0, 3, 2, 2, RESP_OKAY, 1'b0);
    run_txn(0, 3, 2, 1, RESP_OKAY, 1'b0);
  endtask

  task automatic test_early_w();
    load_rand(1);
    run_txn(2, 1, 0, 0, RESP_OKAY, 1'b0);
  endtask

  task automatic test_error_resp();
    load_rand(2);
    run_txn(0, 0, 0, 0, RESP_SLVERR, 1'b0);
    load_rand(0);
    run_txn(0, 0, 1, 0, RESP_DECERR, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) load_rand(i);
      if (expected_winner() < 0) load_rand($urandom_range(0, N - 1));
      run_txn(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom), 1'b0);
    end
    while (expected_winner() >= 0) run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
  endtask

  task automatic test_reset_mid();
    load_rand(2);
    load_rand(1);
    run_txn(0, 0, 3, 0, RESP_OKAY, 1'b1);
    repeat (2) @(negedge ACLK);
    #1;
    n_checks++;
    if (!all_zero()) $display("FAIL reset_hold: outputs nonzero while held in reset");
    else n_pass++;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_quiet();
    @(negedge ACLK);
    ARESETN    = 1'b1;
    model_last = N - 1;
    load_rand(1);
    load_rand(0);
    run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
    run_txn(0, 0, 0, 0, RESP_OKAY, 1'b0);
    idle_check("reset_mid_final_idle");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; p_strb[i] = '0;
    end
    test_reset();
    test_single();
    test_simultaneous();
    test_stalls();
    test_early_w();
    test_error_resp();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_wr_arbiter.md
Name: axi4_lite_wr_arbiter

Overview:
Write-path arbiter that shares one AXI4-Lite slave write port between N_MASTERS master write ports.
It serialises whole write transactions (AW, then W, then B) using round-robin priority, with one outstanding transaction at a time.
It sits between the bus masters and the shared slave. A read-path twin follows later as a separate block.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8); GW = $clog2(N_MASTERS), minimum 1
Addr_Width, 32, address width (from axi4_lite_Defs)
Data_Width, 32, data width (from axi4_lite_Defs); Strb_Width = Data_Width/8

Ports:
ACLK  in  1  bus clock; all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
m_awaddr  in  N_MASTERS*Addr_Width  per-master write address, master i at slice i
m_awvalid  in  N_MASTERS  per-master AW valid; this is the request
m_awready  out  N_MASTERS  per-master AW ready
m_wdata  in  N_MASTERS*Data_Width  per-master write data
m_wstrb  in  N_MASTERS*Strb_Width  per-master write strobes
m_wvalid  in  N_MASTERS  per-master W valid
m_wready  out  N_MASTERS  per-master W ready
m_bresp  out  N_MASTERS*2  per-master write response
m_bvalid  out  N_MASTERS  per-master B valid
m_bready  in  N_MASTERS  per-master B ready
s_awaddr  out  Addr_Width  slave write address
s_awvalid  out  1  slave AW valid
s_awready  in  1  slave AW ready
s_wdata  out  Data_Width  slave write data
s_wstrb  out  Strb_Width  slave strobes
s_wvalid  out  1  slave W valid
s_wready  in  1  slave W ready
s_bresp  in  2  slave response
s_bvalid  in  1  slave B valid
s_bready  out  1  slave B ready

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESETN is asynchronous, active-low.
- FSM uses axi4_lite_Defs::state: IDLE, ADDR, DATA, RESP.
- Registers: state, grant (GW bits), last (GW bits).
- Reset values: state=IDLE, grant=0, last=N_MASTERS-1, so master 0 has first priority. All outputs are 0 during and immediately after reset.
- IDLE:
  - All outputs 0.
  - If any m_awvalid is set, grant = first set bit searching from last+1 and wrapping modulo N_MASTERS; go to ADDR.
  - Arbitration latency is 1 cycle from request to s_awvalid.
- ADDR:
  - s_awaddr = m_awaddr[grant]; s_awvalid = m_awvalid[grant]; m_awready[grant] = s_awready.
  - On s_awvalid & s_awready, go to DATA.
- DATA:
  - s_wdata/s_wstrb/s_wvalid taken from master[grant]; m_wready[grant] = s_wready.
  - On handshake, go to RESP.
- RESP:
  - m_bvalid[grant] = s_bvalid; m_bresp[grant] = s_bresp; s_bready = m_bready[grant].
  - On handshake: last <= grant, go to IDLE.
- All forwarding is combinational, with zero added latency per channel once granted.
- Every ready/valid/data output not named for the current state is 0. Non-granted masters always see awready = wready = bvalid = 0, and bresp = 0.
- W before AW: a master may assert wvalid early. wready stays 0 until DATA, which is legal AXI4-Lite.
- Back-to-back: RESP→IDLE→ADDR, with a minimum of 1 idle cycle between transactions.
- Fairness: a master that just completed has lowest priority next round. Worst-case wait is N_MASTERS-1 transactions.
- Stray slave activity: s_awready/s_wready/s_bvalid outside their state are ignored. bresp is passed through unchanged (SLVERR/DECERR included).
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The in-flight transaction is lost; masters are reset by the same ARESETN.
- Once granted, a master's address and data are latched into neither path. The master must hold VALID and payload stable until handshake, per AXI.

Decomposition:
- Package axi4_lite_Defs gains Strb_Width = Data_Width/8 and a RESP_OKAY/SLVERR/DECERR typedef, alongside the existing widths and state enum.
- Sub-module axi4_lite_rr_arb: combinational round-robin picker (req[N], last → grant, any_req). It is shared with the future read arbiter.

Test Plan:
- Single master: M0 writes 0xDEADBEEF to 0x10, strb 0xF, slave answers OKAY → s_awaddr=0x10, s_wdata=0xDEADBEEF, m_bvalid[0]=1, bresp=00, back in IDLE next cycle.
- Simultaneous request after reset: M0 and M1 request together → M0 served first, then M1. With both re-requesting, grants alternate 0,1,0,1.
- Slave stalls: s_awready low 3 cycles, s_wready low 2 → payload held stable. No advance to the next state until each handshake. M1 sees awready=0 throughout.
- Early W: M1 asserts wvalid 2 cycles before awvalid → m_wready[1] stays 0 until AW handshake completes.
- Error response: slave returns bresp=10 → m_bresp[granted]=10, and the other master's bvalid stays 0.
- Reset during DATA: ARESETN low mid-W → all outputs 0 asynchronously. After release, the arbiter is in IDLE with M0 at first priority.
